// File: rtl/tiny_boot_loader_pkg.sv
// tiny_boot_loader_pkg
//   Definitions shared by the boot loader, its UART receiver and the TinyCore
//   code RAM: loader and receiver state encodings, code RAM geometry and the
//   rule for the length byte of a boot frame.
//   No ports. Import with "import tiny_boot_loader_pkg::*;".
package tiny_boot_loader_pkg;

  // Code RAM geometry, shared with the core side of the RAM mux
  localparam int CODE_RAM_DEPTH = 256;
  localparam int CODE_ADDR_W    = 8;
  localparam int CODE_DATA_W    = 8;

  // One extra bit so that a full 256-byte image can be counted
  localparam int COUNT_W = $clog2(CODE_RAM_DEPTH) + 1;

  // A length byte of zero stands for a full code RAM image
  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  // Loader states
  localparam logic [1:0] ST_LEN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  // UART receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Translate a received length byte into the number of payload bytes
  function automatic logic [COUNT_W-1:0] lenToCount(input logic [CODE_DATA_W-1:0] lenByte);
    if (LEN_ZERO_MEANS_256 && (lenByte == '0)) begin
      return COUNT_W'(CODE_RAM_DEPTH);
    end
    return {1'b0, lenByte};
  endfunction

endpackage

// File: rtl/tiny_boot_loader_uart_rx.sv
// tiny_uart_rx
//   8N1 UART receiver for the boot loader. The line is synchronised, a start
//   bit is detected on a falling edge while idle and re-checked half a bit
//   later, data bits are sampled LSB first at bit centres and the stop bit is
//   sampled at its centre.
// Ports
//   clk_i         clock, all logic on posedge
//   nreset_i      asynchronous active-low reset
//   abort_i       drop any byte in flight and return to idle
//   rx_i          serial input, idle high
//   byte_valid_o  one-cycle pulse, the cycle after a good stop-bit sample
//   byte_data_o   last good byte, held until the next one
//   frame_err_o   one-cycle pulse, the cycle after a low stop-bit sample
module tiny_uart_rx
  import tiny_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       abort_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   rxSync;
  logic                   rxPrevQ;

  logic [1:0]    stateQ, stateD;
  logic [TW-1:0] timerQ, timerD;
  logic [2:0]    bitCntQ, bitCntD;
  logic [7:0]    shiftQ, shiftD;
  logic [7:0]    dataQ, dataD;
  logic          validQ, validD;
  logic          ferrQ, ferrD;

  assign rxSync = syncQ[SYNC_STAGES-1];

  // Synchroniser chain; rxPrevQ is one more stage used only for edge detection.
  // Both reset to the idle (high) line level so reset release is not a start bit.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      syncQ   <= '1;
      rxPrevQ <= 1'b1;
    end else begin
      syncQ[0] <= rx_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncQ[i] <= syncQ[i-1];
      end
      rxPrevQ <= rxSync;
    end
  end

  // Receiver sequencing. The timer counts cycles within the current bit and
  // restarts at every sampling point; abort_i overrides everything.
  always_comb begin
    stateD  = stateQ;
    timerD  = timerQ + TW'(1);
    bitCntD = bitCntQ;
    shiftD  = shiftQ;
    dataD   = dataQ;
    validD  = 1'b0;
    ferrD   = 1'b0;
    case (stateQ)
      RX_IDLE: begin
        timerD = '0;
        if (rxPrevQ && !rxSync) begin
          stateD = RX_START;
        end
      end
      RX_START: begin
        if (timerQ == HALF_LAST) begin
          timerD  = '0;
          bitCntD = '0;
          stateD  = rxSync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timerQ == FULL_LAST) begin
          timerD  = '0;
          shiftD  = {rxSync, shiftQ[7:1]};
          bitCntD = bitCntQ + 3'd1;
          if (bitCntQ == 3'd7) begin
            stateD = RX_STOP;
          end
        end
      end
      default: begin
        if (timerQ == FULL_LAST) begin
          timerD = '0;
          stateD = RX_IDLE;
          if (rxSync) begin
            validD = 1'b1;
            dataD  = shiftQ;
          end else begin
            ferrD = 1'b1;
          end
        end
      end
    endcase
    if (abort_i) begin
      stateD = RX_IDLE;
      timerD = '0;
      validD = 1'b0;
      ferrD  = 1'b0;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      stateQ  <= RX_IDLE;
      timerQ  <= '0;
      bitCntQ <= '0;
      shiftQ  <= '0;
      dataQ   <= '0;
      validQ  <= 1'b0;
      ferrQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      timerQ  <= timerD;
      bitCntQ <= bitCntD;
      shiftQ  <= shiftD;
      dataQ   <= dataD;
      validQ  <= validD;
      ferrQ   <= ferrD;
    end
  end

  assign byte_valid_o = validQ;
  assign byte_data_o  = dataQ;
  assign frame_err_o  = ferrQ;

endmodule

// File: rtl/tiny_boot_loader.sv
// tiny_boot_loader
//   Receives a program image over UART (LEN byte, N payload bytes, XOR CHK
//   byte), writes it to the TinyCore code RAM and keeps the core in reset
//   until the checksum matches.
// Ports
//   clk          clock, all logic on posedge
//   nreset       asynchronous active-low reset
//   rx           UART serial input, idle high
//   boot_req     one-cycle pulse: restart loading, core back into reset
//   core_nreset  core reset, high only in RUN
//   prog_we      code RAM write strobe, one cycle per payload byte
//   prog_addr    code RAM write address
//   prog_wdata   code RAM write data
//   loading      loader owns the code RAM (every state except RUN)
//   err          sticky checksum/framing error, cleared by the next LEN byte
module tiny_boot_loader
  import tiny_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   rx,
  input  logic                   boot_req,
  output logic                   core_nreset,
  output logic                   prog_we,
  output logic [CODE_ADDR_W-1:0] prog_addr,
  output logic [CODE_DATA_W-1:0] prog_wdata,
  output logic                   loading,
  output logic                   err
);

  logic                   byteValid;
  logic [CODE_DATA_W-1:0] byteData;
  logic                   frameErr;

  logic [1:0]             stateQ, stateD;
  logic [COUNT_W-1:0]     countQ, countD;
  logic [CODE_ADDR_W-1:0] addrQ, addrD;
  logic [CODE_DATA_W-1:0] checksumQ, checksumD;
  logic                   errQ, errD;

  // boot_req also flushes the receiver so a half-received byte never lands
  tiny_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) uRx (
    .clk_i       (clk),
    .nreset_i    (nreset),
    .abort_i     (boot_req),
    .rx_i        (rx),
    .byte_valid_o(byteValid),
    .byte_data_o (byteData),
    .frame_err_o (frameErr)
  );

  // Loader FSM with payload counter, write address and running XOR checksum.
  // boot_req takes priority over a byte arriving in the same cycle.
  always_comb begin
    stateD    = stateQ;
    countD    = countQ;
    addrD     = addrQ;
    checksumD = checksumQ;
    errD      = errQ;
    if (boot_req) begin
      stateD = ST_LEN;
    end else begin
      case (stateQ)
        ST_LEN: begin
          if (byteValid) begin
            countD    = lenToCount(byteData);
            addrD     = '0;
            checksumD = '0;
            errD      = 1'b0;
            stateD    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (byteValid) begin
            checksumD = checksumQ ^ byteData;
            addrD     = addrQ + CODE_ADDR_W'(1);
            countD    = countQ - COUNT_W'(1);
            if (countD == '0) begin
              stateD = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (byteValid) begin
            if (byteData == checksumQ) begin
              stateD = ST_RUN;
            end else begin
              errD   = 1'b1;
              stateD = ST_LEN;
            end
          end
        end
        default: ;
      endcase
      if (frameErr && (stateQ != ST_RUN)) begin
        errD   = 1'b1;
        stateD = ST_LEN;
      end
    end
  end

  // Loader state registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stateQ    <= ST_LEN;
      countQ    <= '0;
      addrQ     <= '0;
      checksumQ <= '0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      countQ    <= countD;
      addrQ     <= addrD;
      checksumQ <= checksumD;
      errQ      <= errD;
    end
  end

  // The strobe is decoded straight from the registered byte_valid pulse so it
  // can only ever appear while the registered state is LOAD.
  assign prog_we     = (stateQ == ST_LOAD) && byteValid && !boot_req;
  assign prog_addr   = addrQ;
  assign prog_wdata  = byteData;
  assign loading     = (stateQ != ST_RUN);
  assign core_nreset = (stateQ == ST_RUN);
  assign err         = errQ;

endmodule

// File: tb/tb_tiny_boot_loader.sv
// tb_tiny_boot_loader
//   Directed bench for tiny_boot_loader with CLKS_PER_BIT=4. Expected code RAM
//   writes are queued as payload bytes are sent and popped when prog_we fires.
module tb_tiny_boot_loader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       rx = 1'b1;
  logic       boot_req = 1'b0;
  logic       core_nreset;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_wdata;
  logic       loading;
  logic       err;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expQ[$];
  int  assertCount = 0;
  int  failCount = 0;
  int  weCount = 0;
  logic [7:0] expAddr;
  logic [7:0] chk;
  int  weBefore;

  tiny_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .rx         (rx),
    .boot_req   (boot_req),
    .core_nreset(core_nreset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .loading    (loading),
    .err        (err)
  );

  always #5 clk = ~clk;

  // One immediate assertion per comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one UART frame starting at a negedge; nBits < 10 stops early,
  // leaving the line at the last driven bit
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit = 1'b1,
                               input int nBits = 10);
    logic [9:0] frame;
    frame = {stopBit, value, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    if (nBits == 10) rx = 1'b1;
  endtask

  // Payload byte: queue the write it must cause, then send it
  task automatic sendPayload(input logic [7:0] value);
    expQ.push_back('{addr: expAddr, data: value});
    expAddr = expAddr + 8'd1;
    chk = chk ^ value;
    applyStimulus(value);
  endtask

  task automatic startImage(input logic [7:0] len);
    expAddr = 8'd0;
    chk = 8'd0;
    applyStimulus(len);
  endtask

  task automatic pulseBootReq();
    boot_req = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  // Send CHK and check the core is released exactly one cycle after byte_valid
  task automatic finishGood(input string tag);
    applyStimulus(chk);
    @(negedge clk);
    checkOutput({tag, "_core_early"}, 32'(core_nreset), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_core_run"}, 32'(core_nreset), 32'd1);
    checkOutput({tag, "_loading"}, 32'(loading), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_writes_left"}, 32'(expQ.size()), 32'd0);
  endtask

  // Scoreboard side: every strobe must match the oldest queued write
  always @(negedge clk) begin
    if (nreset) begin
      assertCount++;
      assert (!(core_nreset && loading)) else begin
        failCount++;
        $error("[TB] FAIL core_while_loading observed=1 expected=0");
      end
      if (prog_we === 1'b1) begin
        weCount++;
        assertCount++;
        assert (expQ.size() != 0) else begin
          failCount++;
          $error("[TB] FAIL unexpected_we observed addr=%0h data=%0h expected no strobe",
                 prog_addr, prog_wdata);
        end
        if (expQ.size() != 0) begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("wr_addr", 32'(prog_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(prog_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_core", 32'(core_nreset), 32'd0);
    checkOutput("rst_we", 32'(prog_we), 32'd0);
    checkOutput("rst_addr", 32'(prog_addr), 32'd0);
    checkOutput("rst_wdata", 32'(prog_wdata), 32'd0);
    checkOutput("rst_loading", 32'(loading), 32'd1);
    checkOutput("rst_err", 32'(err), 32'd0);
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    // Basic three-byte image
    startImage(8'd3);
    sendPayload(8'h51);
    sendPayload(8'h0A);
    sendPayload(8'h52);
    checkOutput("img1_chk_value", 32'(chk), 32'h09);
    finishGood("img1");

    // boot_req in RUN puts the core back into reset on the next edge
    pulseBootReq();
    checkOutput("bootreq_run_core", 32'(core_nreset), 32'd0);
    checkOutput("bootreq_run_loading", 32'(loading), 32'd1);

    // Wrong checksum, then the same image with the right one
    startImage(8'd3);
    sendPayload(8'h51);
    sendPayload(8'h0A);
    sendPayload(8'h52);
    applyStimulus(8'h00);
    repeat (2) @(negedge clk);
    checkOutput("badchk_err", 32'(err), 32'd1);
    checkOutput("badchk_core", 32'(core_nreset), 32'd0);
    checkOutput("badchk_loading", 32'(loading), 32'd1);
    startImage(8'd3);
    repeat (2) @(negedge clk);
    checkOutput("err_clear_on_len", 32'(err), 32'd0);
    sendPayload(8'h51);
    sendPayload(8'h0A);
    sendPayload(8'h52);
    finishGood("img2");

    // Full 256-byte image, address wraps back to 0
    pulseBootReq();
    weBefore = weCount;
    startImage(8'd0);
    for (int k = 0; k < 256; k++) sendPayload(8'(k));
    checkOutput("img256_chk_value", 32'(chk), 32'h00);
    finishGood("img256");
    checkOutput("img256_strobes", 32'(weCount - weBefore), 32'd256);
    checkOutput("img256_addr_wrap", 32'(prog_addr), 32'd0);

    // Stop bit low on the second payload byte
    pulseBootReq();
    startImage(8'd3);
    sendPayload(8'h51);
    applyStimulus(8'h0A, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("ferr_err", 32'(err), 32'd1);
    checkOutput("ferr_loading", 32'(loading), 32'd1);
    checkOutput("ferr_core", 32'(core_nreset), 32'd0);
    startImage(8'd1);
    sendPayload(8'hC5);
    finishGood("ferr_recover");

    // boot_req mid-byte in LOAD drops the partial byte
    pulseBootReq();
    startImage(8'd3);
    sendPayload(8'h33);
    applyStimulus(8'hA5, 1'b1, 5);
    pulseBootReq();
    checkOutput("bootreq_load_core", 32'(core_nreset), 32'd0);
    checkOutput("bootreq_load_loading", 32'(loading), 32'd1);
    repeat (60) @(negedge clk);

    // One-clock glitch while waiting for a payload byte must not make a byte
    startImage(8'd1);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    sendPayload(8'h77);
    finishGood("glitch");

    // Async reset mid-byte during LOAD
    pulseBootReq();
    startImage(8'd2);
    sendPayload(8'hC3);
    applyStimulus(8'h5A, 1'b1, 5);
    checkOutput("pre_rst_addr", 32'(prog_addr), 32'd1);
    #2;
    nreset = 1'b0;
    #1;
    checkOutput("midrst_core", 32'(core_nreset), 32'd0);
    checkOutput("midrst_we", 32'(prog_we), 32'd0);
    checkOutput("midrst_addr", 32'(prog_addr), 32'd0);
    checkOutput("midrst_wdata", 32'(prog_wdata), 32'd0);
    checkOutput("midrst_loading", 32'(loading), 32'd1);
    checkOutput("midrst_err", 32'(err), 32'd0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
